register_file: RTL and testbench
================================

Name: register_file

Overview:
- Architectural integer register file with per-register rename tags.
- Sits between the decoder/issue stage and the reorder buffer, downstream of ROB commit.
- Issue side: supplies operand values and ROB dependency tags for rs1/rs2, and records the new producer tag for rd on every issued instruction.
- Commit side: ROB commit writes the value and clears the tag only if the committing entry is still the register's youngest producer.

Parameters:
XLEN, 32, data width
REG_CNT_WIDTH, 5, register index width (32 registers)
ROB_SIZE_WIDTH, 4, ROB index width (16 entries)
DEPENDENCY_WIDTH, 5, tag width; all-ones = no dependency, otherwise low ROB_SIZE_WIDTH bits = ROB id

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rdy  in  1  global enable; when low, all state holds
flush  in  1  misprediction flush from ROB
stall  in  1  issue stall (ROB/RS/LSB full)
dec_ready  in  1  decoder issues an instruction this cycle
dec_rs1  in  REG_CNT_WIDTH  source register 1 of issuing instruction
dec_rs2  in  REG_CNT_WIDTH  source register 2 of issuing instruction
dec_rd  in  REG_CNT_WIDTH  destination of issuing instruction (0 for no destination)
rob_tail_id  in  ROB_SIZE_WIDTH  ROB slot allocated to the issuing instruction
rob_head_id  in  ROB_SIZE_WIDTH  current ROB head (registered)
rob_rf_enable  in  1  registered commit write strobe
rob_rf_rd  in  REG_CNT_WIDTH  commit destination register
rob_rf_val  in  XLEN  commit value
rf_dep1  out  DEPENDENCY_WIDTH  tag of dec_rs1 (combinational)
rf_val1  out  XLEN  value of dec_rs1 (combinational)
rf_dep2  out  DEPENDENCY_WIDTH  tag of dec_rs2 (combinational)
rf_val2  out  XLEN  value of dec_rs2 (combinational)

Behaviour:
- State:
  - regs[0..31], XLEN each.
  - dep[0..31], DEPENDENCY_WIDTH each; NONE = all-ones.
- Reset (rst high at posedge, overrides rdy):
  - all regs = 0, all dep = NONE.
  - Outputs are combinational, so rf_dep* = NONE and rf_val* = 0 for every index.
- Commit id: because rob_rf_* are registered one cycle after the head advances, commit_id = rob_head_id - 1, mod 2^ROB_SIZE_WIDTH. Wrap case: head = 0 gives commit_id = 15.
- Commit write (rdy high, rob_rf_enable high, rob_rf_rd != 0):
  - regs[rd] <= rob_rf_val.
  - dep[rd] <= NONE only if dep[rd] == {1'b0, commit_id}; otherwise the tag is kept (a younger producer exists).
- Issue (rdy high, !flush, !stall, dec_ready high, dec_rd != 0): dep[dec_rd] <= {1'b0, rob_tail_id}.
- Same-cycle issue and commit to the same rd: the issue tag wins; the value is still written.
- Flush (rdy high, flush high):
  - all dep <= NONE; issue is ignored.
  - A commit write presented in the same cycle is still performed (e.g. JALR link value).
- Read path (combinational, for x = rs1/rs2):
  - x == 0: dep = NONE, val = 0.
  - Otherwise, commit bypass: if rob_rf_enable, rob_rf_rd == x, and dep[x] == {1'b0, commit_id}, output dep = NONE and val = rob_rf_val.
  - Otherwise output dep[x] and regs[x].
  - Reads see pre-issue state; an instruction reading its own rd gets the old producer.
- x0: never written, never tagged.
- rdy low: no state change regardless of other inputs.
- Latency: commit value visible to the register array the next cycle; visible to readers in the same cycle via the bypass.

Test Plan:
1. Reset, then read rs1 = 5, rs2 = 0 -> rf_dep1 = 5'b11111, rf_val1 = 0, rf_dep2 = 5'b11111, rf_val2 = 0.
2. Issue rd = 3 with rob_tail_id = 2. Later, head = 3 with rob_rf_enable, rd = 3, val = 0x1234.
   - Same cycle, rs1 = 3 reads dep NONE, val 0x1234 (bypass).
   - Next cycle dep[3] = NONE, regs[3] = 0x1234.
3. Issue rd = 7 at tail = 4, then rd = 7 at tail = 5. Commit rd = 7 with head = 5 (id 4), val = 9 -> regs[7] = 9, rs1 = 7 still reports dep 5, val 9.
4. Wrap: issue rd = 1 at tail = 15, commit with head = 0 -> dep[1] = NONE.
5. Tag rd = 2 at tail 6 and rd = 4 at tail 7. Assert flush together with commit rd = 9 (val 0xABC) and dec_ready rd = 10 at tail 8:
   - Next cycle all deps NONE, regs[9] = 0xABC, dep[10] = NONE.
6. Issue or commit to rd = 0 with val 0xFF -> regs[0] stays 0, dep NONE. With rdy = 0, an issue rd = 6 is ignored.

Source files
------------

// File: rtl/register_file_if.sv
// Issue/commit/read bundle between decoder, ROB and the architectural register file.
interface register_file_if #(
  parameter int XLEN             = 32,
  parameter int REG_CNT_WIDTH    = 5,
  parameter int ROB_SIZE_WIDTH   = 4,
  parameter int DEPENDENCY_WIDTH = 5
);
  logic                        rdy;
  logic                        flush;
  logic                        stall;
  logic                        dec_ready;
  logic [REG_CNT_WIDTH-1:0]    dec_rs1;
  logic [REG_CNT_WIDTH-1:0]    dec_rs2;
  logic [REG_CNT_WIDTH-1:0]    dec_rd;
  logic [ROB_SIZE_WIDTH-1:0]   rob_tail_id;
  logic [ROB_SIZE_WIDTH-1:0]   rob_head_id;
  logic                        rob_rf_enable;
  logic [REG_CNT_WIDTH-1:0]    rob_rf_rd;
  logic [XLEN-1:0]             rob_rf_val;
  logic [DEPENDENCY_WIDTH-1:0] rf_dep1;
  logic [XLEN-1:0]             rf_val1;
  logic [DEPENDENCY_WIDTH-1:0] rf_dep2;
  logic [XLEN-1:0]             rf_val2;

  modport master (
    output rdy, flush, stall, dec_ready, dec_rs1, dec_rs2, dec_rd,
           rob_tail_id, rob_head_id, rob_rf_enable, rob_rf_rd, rob_rf_val,
    input  rf_dep1, rf_val1, rf_dep2, rf_val2
  );

  modport slave (
    input  rdy, flush, stall, dec_ready, dec_rs1, dec_rs2, dec_rd,
           rob_tail_id, rob_head_id, rob_rf_enable, rob_rf_rd, rob_rf_val,
    output rf_dep1, rf_val1, rf_dep2, rf_val2
  );
endinterface

// File: rtl/register_file.sv
// Architectural register file with per-register producer tags; commit clears a tag
// only when the committing ROB entry is still the youngest producer of that register.
module register_file #(
  parameter int XLEN             = 32,
  parameter int REG_CNT_WIDTH    = 5,
  parameter int ROB_SIZE_WIDTH   = 4,
  parameter int DEPENDENCY_WIDTH = 5
) (
  input  logic           clk,
  input  logic           rst,
  register_file_if.slave bus
);
  localparam int unsigned REG_CNT = 1 << REG_CNT_WIDTH;
  localparam logic [DEPENDENCY_WIDTH-1:0] NONE = '1;

  logic [XLEN-1:0]             r_regs [REG_CNT];
  logic [DEPENDENCY_WIDTH-1:0] r_dep  [REG_CNT];

  logic [ROB_SIZE_WIDTH-1:0]   w_commit_id;
  logic [DEPENDENCY_WIDTH-1:0] w_commit_tag;
  logic [DEPENDENCY_WIDTH-1:0] w_issue_tag;
  logic                        w_commit_wr;
  logic                        w_issue;
  logic                        w_byp1;
  logic                        w_byp2;

  // Commit strobes arrive one cycle after the head advanced, so the committing id is head-1.
  assign w_commit_id  = bus.rob_head_id - ROB_SIZE_WIDTH'(1);
  assign w_commit_tag = DEPENDENCY_WIDTH'(w_commit_id);
  assign w_issue_tag  = DEPENDENCY_WIDTH'(bus.rob_tail_id);
  assign w_commit_wr  = bus.rob_rf_enable && (bus.rob_rf_rd != '0);
  assign w_issue      = !bus.flush && !bus.stall && bus.dec_ready && (bus.dec_rd != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < REG_CNT; i++) begin
        r_regs[i] <= '0;
        r_dep[i]  <= NONE;
      end
    end else if (bus.rdy) begin
      if (w_commit_wr) begin
        r_regs[bus.rob_rf_rd] <= bus.rob_rf_val;
        if (r_dep[bus.rob_rf_rd] == w_commit_tag) begin
          r_dep[bus.rob_rf_rd] <= NONE;
        end
      end
      // Later assignments override the commit clear: flush wipes all tags, issue tag wins.
      if (bus.flush) begin
        for (int unsigned i = 0; i < REG_CNT; i++) begin
          r_dep[i] <= NONE;
        end
      end else if (w_issue) begin
        r_dep[bus.dec_rd] <= w_issue_tag;
      end
    end
  end

  assign w_byp1 = bus.rob_rf_enable && (bus.rob_rf_rd == bus.dec_rs1) &&
                  (r_dep[bus.dec_rs1] == w_commit_tag);
  assign w_byp2 = bus.rob_rf_enable && (bus.rob_rf_rd == bus.dec_rs2) &&
                  (r_dep[bus.dec_rs2] == w_commit_tag);

  always_comb begin
    bus.rf_dep1 = NONE;
    bus.rf_val1 = '0;
    if (bus.dec_rs1 != '0) begin
      if (w_byp1) begin
        bus.rf_val1 = bus.rob_rf_val;
      end else begin
        bus.rf_dep1 = r_dep[bus.dec_rs1];
        bus.rf_val1 = r_regs[bus.dec_rs1];
      end
    end
  end

  always_comb begin
    bus.rf_dep2 = NONE;
    bus.rf_val2 = '0;
    if (bus.dec_rs2 != '0) begin
      if (w_byp2) begin
        bus.rf_val2 = bus.rob_rf_val;
      end else begin
        bus.rf_dep2 = r_dep[bus.dec_rs2];
        bus.rf_val2 = r_regs[bus.dec_rs2];
      end
    end
  end
endmodule

// File: tb/tb_register_file.sv
// Directed + randomized bench for register_file against an integer-level reference model.
module tb_register_file;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  // Reference state: m_dep holds the producing ROB id, or -1 when the value is architectural.
  logic [31:0] m_regs [32];
  int          m_dep  [32];

  register_file_if #(.XLEN(32), .REG_CNT_WIDTH(5), .ROB_SIZE_WIDTH(4), .DEPENDENCY_WIDTH(5)) bus_if ();

  register_file #(.XLEN(32), .REG_CNT_WIDTH(5), .ROB_SIZE_WIDTH(4), .DEPENDENCY_WIDTH(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int commit_id();
    return (int'(bus_if.rob_head_id) + 15) % 16;
  endfunction

  task automatic expect_port(input logic [4:0] x, output logic [31:0] edep, output logic [31:0] ev);
    if (x == 0) begin
      edep = 31; ev = 0;
    end else if (bus_if.rob_rf_enable && bus_if.rob_rf_rd == x && m_dep[x] == commit_id()) begin
      edep = 31; ev = bus_if.rob_rf_val;
    end else begin
      edep = (m_dep[x] < 0) ? 31 : m_dep[x];
      ev = m_regs[x];
    end
  endtask

  task automatic chk_reads(input string tag);
    logic [31:0] d1, v1, d2, v2;
    expect_port(bus_if.dec_rs1, d1, v1);
    expect_port(bus_if.dec_rs2, d2, v2);
    check({tag, ".dep1"}, 32'(bus_if.rf_dep1), d1);
    check({tag, ".val1"}, bus_if.rf_val1, v1);
    check({tag, ".dep2"}, 32'(bus_if.rf_dep2), d2);
    check({tag, ".val2"}, bus_if.rf_val2, v2);
  endtask

  task automatic model_clock();
    int cid;
    int rd;
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] = 0; m_dep[i] = -1;
      end
    end else if (bus_if.rdy) begin
      cid = commit_id();
      rd  = bus_if.rob_rf_rd;
      if (bus_if.rob_rf_enable && rd != 0) begin
        m_regs[rd] = bus_if.rob_rf_val;
        if (m_dep[rd] == cid) m_dep[rd] = -1;
      end
      if (bus_if.flush) begin
        for (int i = 0; i < 32; i++) m_dep[i] = -1;
      end else if (!bus_if.stall && bus_if.dec_ready && bus_if.dec_rd != 0) begin
        m_dep[bus_if.dec_rd] = bus_if.rob_tail_id;
      end
    end
  endtask

  // Inputs are driven just after the falling edge; reads are checked 1ns later.
  task automatic step(input string tag);
    #1;
    chk_reads(tag);
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic idle();
    bus_if.rdy = 1'b1; bus_if.flush = 1'b0; bus_if.stall = 1'b0;
    bus_if.dec_ready = 1'b0; bus_if.dec_rd = '0;
    bus_if.rob_rf_enable = 1'b0; bus_if.rob_rf_rd = '0; bus_if.rob_rf_val = '0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [3:0] tail);
    idle();
    bus_if.dec_ready = 1'b1; bus_if.dec_rd = rd; bus_if.rob_tail_id = tail;
  endtask

  task automatic commit(input logic [4:0] rd, input logic [3:0] head, input logic [31:0] v);
    idle();
    bus_if.rob_rf_enable = 1'b1; bus_if.rob_rf_rd = rd; bus_if.rob_head_id = head; bus_if.rob_rf_val = v;
  endtask

  initial begin
    checks = 0; errors = 0;
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 'x; m_dep[i] = -1;
    end
    rst = 1'b1;
    idle();
    bus_if.dec_rs1 = '0; bus_if.dec_rs2 = '0; bus_if.rob_tail_id = '0; bus_if.rob_head_id = '0;
    @(negedge clk);
    @(posedge clk); model_clock(); @(negedge clk);
    rst = 1'b0;

    // Reset values
    bus_if.dec_rs1 = 5; bus_if.dec_rs2 = 0;
    #1;
    check("rst.dep1", 32'(bus_if.rf_dep1), 32'h1f);
    check("rst.val1", bus_if.rf_val1, 32'h0);
    check("rst.dep2", 32'(bus_if.rf_dep2), 32'h1f);
    check("rst.val2", bus_if.rf_val2, 32'h0);
    step("rst");

    // Tag, then commit with bypass
    issue(3, 2); bus_if.dec_rs1 = 3; step("iss3");
    commit(3, 3, 32'h1234); bus_if.dec_rs1 = 3;
    #1;
    check("byp.dep1", 32'(bus_if.rf_dep1), 32'h1f);
    check("byp.val1", bus_if.rf_val1, 32'h1234);
    step("byp");
    idle(); bus_if.dec_rs1 = 3;
    #1;
    check("post.dep1", 32'(bus_if.rf_dep1), 32'h1f);
    check("post.val1", bus_if.rf_val1, 32'h1234);
    step("post");

    // Younger producer survives an older commit
    issue(7, 4); step("iss7a");
    issue(7, 5); step("iss7b");
    commit(7, 5, 32'd9); bus_if.dec_rs1 = 7;
    #1;
    check("young.nobyp", 32'(bus_if.rf_dep1), 32'd5);
    step("c7");
    idle(); bus_if.dec_rs1 = 7;
    #1;
    check("young.dep1", 32'(bus_if.rf_dep1), 32'd5);
    check("young.val1", bus_if.rf_val1, 32'd9);
    step("young");

    // Commit id wraps from head 0 to 15
    issue(1, 15); step("iss1");
    commit(1, 0, 32'h55); bus_if.dec_rs1 = 1; step("wrapc");
    idle(); bus_if.dec_rs1 = 1;
    #1;
    check("wrap.dep1", 32'(bus_if.rf_dep1), 32'h1f);
    check("wrap.val1", bus_if.rf_val1, 32'h55);
    step("wrap");

    // Flush with concurrent commit and issue
    issue(2, 6); step("iss2");
    issue(4, 7); step("iss4");
    commit(9, 3, 32'hABC); bus_if.flush = 1'b1;
    bus_if.dec_ready = 1'b1; bus_if.dec_rd = 10; bus_if.rob_tail_id = 8;
    step("flush");
    idle(); bus_if.dec_rs1 = 2; bus_if.dec_rs2 = 4;
    #1;
    check("fl.dep2r", 32'(bus_if.rf_dep1), 32'h1f);
    check("fl.dep4r", 32'(bus_if.rf_dep2), 32'h1f);
    step("fl1");
    bus_if.dec_rs1 = 9; bus_if.dec_rs2 = 10;
    #1;
    check("fl.val9", bus_if.rf_val1, 32'hABC);
    check("fl.dep10", 32'(bus_if.rf_dep2), 32'h1f);
    step("fl2");

    // x0, rdy low, stall
    issue(0, 3); bus_if.rob_rf_enable = 1'b1; bus_if.rob_rf_rd = 0; bus_if.rob_rf_val = 32'hFF;
    bus_if.rob_head_id = 4; step("x0");
    idle(); bus_if.rdy = 1'b0; bus_if.dec_ready = 1'b1; bus_if.dec_rd = 6; bus_if.rob_tail_id = 9;
    step("rdy0");
    idle(); bus_if.stall = 1'b1; bus_if.dec_ready = 1'b1; bus_if.dec_rd = 11; bus_if.rob_tail_id = 9;
    step("stall");
    idle(); bus_if.dec_rs1 = 6; bus_if.dec_rs2 = 11;
    #1;
    check("rdy0.dep6", 32'(bus_if.rf_dep1), 32'h1f);
    check("stall.dep11", 32'(bus_if.rf_dep2), 32'h1f);
    step("hold");

    // Random traffic on a small register window so tags and commits collide often
    for (int n = 0; n < 400; n++) begin
      logic [4:0] crd;
      bus_if.rdy = ($urandom_range(9) != 0);
      bus_if.flush = ($urandom_range(19) == 0);
      bus_if.stall = ($urandom_range(4) == 0);
      bus_if.dec_ready = $urandom_range(1);
      bus_if.dec_rd = 5'($urandom_range(7));
      bus_if.rob_tail_id = 4'($urandom);
      bus_if.dec_rs1 = 5'($urandom_range(7));
      bus_if.dec_rs2 = 5'($urandom_range(7));
      crd = 5'($urandom_range(7));
      bus_if.rob_rf_enable = $urandom_range(1);
      bus_if.rob_rf_rd = crd;
      bus_if.rob_rf_val = $urandom;
      if (m_dep[crd] >= 0 && $urandom_range(1) == 1)
        bus_if.rob_head_id = 4'((m_dep[crd] + 1) % 16);
      else
        bus_if.rob_head_id = 4'($urandom);
      rst = (n == 200);
      step("rand");
      rst = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
